// File: rtl/page_table_walker_pkg.sv
// Shared definitions for the two-level page-table walker: PTE field
// positions, virtual-address index shifts and the walker FSM states.
package page_table_walker_pkg;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 12;
  localparam int PTE_PPN_MSB = 31;

  // VPN[1] sits above bit 22, VPN[0] above bit 12; the same split applies
  // to the PPN when a level-1 leaf maps a 4 MiB superpage.
  localparam int VPN1_SHIFT  = 22;
  localparam int VPN0_SHIFT  = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    RESP    = 3'd5
  } walk_state_e;

  // A PTE is a leaf as soon as any of R/W/X is set.
  function automatic logic pte_is_leaf(input logic [31:0] pte);
    return |pte[PTE_X:PTE_R];
  endfunction

  // Write permission without read permission is a reserved encoding.
  function automatic logic pte_perm_illegal(input logic [31:0] pte);
    return pte[PTE_W] & ~pte[PTE_R];
  endfunction

  // Permission field reported as {X,W,R}.
  function automatic logic [2:0] pte_perm(input logic [31:0] pte);
    return pte[PTE_X:PTE_R];
  endfunction

endpackage

// File: rtl/page_table_walker.sv
// Two-level page-table walker: takes a virtual address and root table base,
// reads up to two PTEs through a valid/ready memory port, and returns the
// physical address and {X,W,R} permissions, or a fault.
module page_table_walker
  import page_table_walker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req_valid_i,
  output logic        walk_req_ready_o,
  input  logic [31:0] walk_vaddr_i,
  input  logic [31:0] root_base_i,
  output logic        walk_resp_valid_o,
  input  logic        walk_resp_ready_i,
  output logic [31:0] walk_paddr_o,
  output logic [2:0]  walk_perm_o,
  output logic        walk_fault_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  walk_state_e state, state_nxt;

  logic [31:0]      vaddr_q;
  logic [19:0]      root_ppn_q;
  logic [19:0]      l0_ppn_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] paddr_q;
  logic [2:0]  perm_q;
  logic        fault_q;

  logic        req_accept;
  logic        ppn_load;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        walk_fail;
  logic        res_load;
  logic        res_fault;
  logic [31:0] res_paddr;
  logic [2:0]  res_perm;
  logic [31:0] l1_addr;
  logic [31:0] l0_addr;

  // Low PTE flag bits and the page offset of the root base carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{mem_data_i[PTE_PPN_LSB-1:PTE_X+1], root_base_i[PTE_PPN_LSB-1:0]};

  // PTE addresses; 32-bit adds wrap silently on overflow.
  assign l1_addr = {root_ppn_q, 12'b0} + 32'({vaddr_q[31:VPN1_SHIFT], 2'b00});
  assign l0_addr = {l0_ppn_q, 12'b0}   + 32'({vaddr_q[VPN1_SHIFT-1:VPN0_SHIFT], 2'b00});

  assign walk_paddr_o = paddr_q;
  assign walk_perm_o  = perm_q;
  assign walk_fault_o = fault_q;

  // Next-state and handshake decode; PTE checks happen as the data arrives.
  always_comb begin
    state_nxt         = state;
    walk_req_ready_o  = 1'b0;
    walk_resp_valid_o = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_addr_o        = '0;
    mem_resp_ready_o  = 1'b0;
    req_accept        = 1'b0;
    ppn_load          = 1'b0;
    cnt_clr           = 1'b0;
    cnt_inc           = 1'b0;
    walk_fail         = 1'b0;
    res_load          = 1'b0;
    res_fault         = 1'b0;
    res_paddr         = '0;
    res_perm          = '0;

    case (state)
      IDLE: begin
        walk_req_ready_o = ~rst;
        req_accept       = walk_req_valid_i & ~rst;
        if (req_accept) state_nxt = L1_REQ;
      end

      L1_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = l1_addr;
        if (mem_req_ready_i) begin
          cnt_clr   = 1'b1;
          state_nxt = L1_WAIT;
        end
      end

      L1_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          if (!mem_data_i[PTE_V]) begin
            walk_fail = 1'b1;
          end else if (pte_is_leaf(mem_data_i)) begin
            // A superpage leaf must have PPN[9:0] clear.
            if (pte_perm_illegal(mem_data_i) ||
                (mem_data_i[VPN1_SHIFT-1:PTE_PPN_LSB] != '0)) begin
              walk_fail = 1'b1;
            end else begin
              res_load  = 1'b1;
              res_paddr = {mem_data_i[PTE_PPN_MSB:VPN1_SHIFT], vaddr_q[VPN1_SHIFT-1:0]};
              res_perm  = pte_perm(mem_data_i);
              state_nxt = RESP;
            end
          end else begin
            ppn_load  = 1'b1;
            state_nxt = L0_REQ;
          end
        end else if (wait_cnt == CNT_LAST) begin
          walk_fail = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      L0_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = l0_addr;
        if (mem_req_ready_i) begin
          cnt_clr   = 1'b1;
          state_nxt = L0_WAIT;
        end
      end

      L0_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          if (!mem_data_i[PTE_V] || !pte_is_leaf(mem_data_i) ||
              pte_perm_illegal(mem_data_i)) begin
            walk_fail = 1'b1;
          end else begin
            res_load  = 1'b1;
            res_paddr = {mem_data_i[PTE_PPN_MSB:PTE_PPN_LSB], vaddr_q[VPN0_SHIFT-1:0]};
            res_perm  = pte_perm(mem_data_i);
            state_nxt = RESP;
          end
        end else if (wait_cnt == CNT_LAST) begin
          walk_fail = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      RESP: begin
        walk_resp_valid_o = 1'b1;
        if (walk_resp_ready_i) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // Every fault reports zero address and permissions.
    if (walk_fail) begin
      res_load  = 1'b1;
      res_fault = 1'b1;
      res_paddr = '0;
      res_perm  = '0;
      state_nxt = RESP;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory-response wait counter, restarted on each entry to a wait state.
  always_ff @(posedge clk) begin
    if (rst)          wait_cnt <= '0;
    else if (cnt_clr) wait_cnt <= '0;
    else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
  end

  // Result registers feeding the response port; cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q <= '0;
      perm_q  <= '0;
      fault_q <= 1'b0;
    end else if (res_load) begin
      paddr_q <= res_paddr;
      perm_q  <= res_perm;
      fault_q <= res_fault;
    end
  end

  // Walk operands: request fields on acceptance, next-level table base from the L1 PTE.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      vaddr_q    <= walk_vaddr_i;
      root_ppn_q <= root_base_i[31:PTE_PPN_LSB];
    end
    if (ppn_load) l0_ppn_q <= mem_data_i[PTE_PPN_MSB:PTE_PPN_LSB];
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed scenarios plus
// randomized walks compared against a behavioural translation model.
module tb_page_table_walker;

  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        walk_req_valid_i;
  logic        walk_req_ready_o;
  logic [31:0] walk_vaddr_i;
  logic [31:0] root_base_i;
  logic        walk_resp_valid_o;
  logic        walk_resp_ready_i;
  logic [31:0] walk_paddr_o;
  logic [2:0]  walk_perm_o;
  logic        walk_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;

  page_table_walker #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .walk_req_valid_i  (walk_req_valid_i),
    .walk_req_ready_o  (walk_req_ready_o),
    .walk_vaddr_i      (walk_vaddr_i),
    .root_base_i       (root_base_i),
    .walk_resp_valid_o (walk_resp_valid_o),
    .walk_resp_ready_i (walk_resp_ready_i),
    .walk_paddr_o      (walk_paddr_o),
    .walk_perm_o       (walk_perm_o),
    .walk_fault_o      (walk_fault_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_ready_o  (mem_resp_ready_o),
    .mem_data_i        (mem_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory-model knobs, set by the main sequence.
  int cfg_stall   = 0;
  int cfg_rsp_dly = 0;
  bit no_resp     = 1'b0;
  int stale_cnt   = 0;
  int req_count   = 0;

  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Translation straight from the PTE format rules.
  function automatic void model(input logic [31:0] root, input logic [31:0] va,
                                output logic [31:0] pa, output logic [2:0] perm,
                                output logic fault, output int nreq);
    logic [31:0] pte, addr;
    pa = 0; perm = 0; fault = 1'b1; nreq = 1;
    addr = (root & 32'hFFFF_F000) + (va >> 22) * 4;
    pte  = mem_rd(addr);
    if (pte[0] && pte[3:1] != 3'b000) begin
      if ((pte & 32'h003F_F000) == 0 && !(pte[2] && !pte[1])) begin
        fault = 1'b0;
        pa    = (pte & 32'hFFC0_0000) | (va & 32'h003F_FFFF);
        perm  = pte[3:1];
      end
    end else if (pte[0]) begin
      nreq = 2;
      addr = (pte & 32'hFFFF_F000) + ((va >> 12) & 32'h3FF) * 4;
      pte  = mem_rd(addr);
      if (pte[0] && pte[3:1] != 3'b000 && !(pte[2] && !pte[1])) begin
        fault = 1'b0;
        pa    = (pte & 32'hFFFF_F000) | (va & 32'h0000_0FFF);
        perm  = pte[3:1];
      end
    end
  endfunction

  // Memory responder: drives just after each falling edge.
  initial begin : mem_model
    bit          pend, active;
    logic [31:0] pend_addr, addr0;
    int          stall, rdly;
    pend = 0; active = 0; stall = 0; rdly = 0; pend_addr = 0; addr0 = 0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_data_i = 0;
    forever begin
      @(negedge clk); #1;
      mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_data_i = 0;
      if (rst) begin
        pend = 0; active = 0;
      end else begin
        if (stale_cnt > 0) begin
          stale_cnt--;
          mem_resp_valid_i = 1; mem_data_i = 32'h0000_5007;
        end else if (pend && !no_resp) begin
          if (rdly > 0) rdly--;
          else begin
            mem_resp_valid_i = 1;
            mem_data_i = mem_rd(pend_addr);
            if (mem_resp_ready_o) pend = 0;
          end
        end
        if (mem_req_valid_o) begin
          if (!active) begin
            active = 1; stall = cfg_stall; addr0 = mem_addr_o;
          end else begin
            chk("mem_addr_stable", mem_addr_o, addr0);
          end
          if (stall > 0) stall--;
          else begin
            mem_req_ready_i = 1; active = 0; pend = 1;
            pend_addr = mem_addr_o; rdly = cfg_rsp_dly; req_count++;
          end
        end
      end
    end
  end

  // Issue one request; lat = cycles from the acceptance cycle to resp valid.
  task automatic run_walk(input string tag, input logic [31:0] root, input logic [31:0] va,
                          output int lat);
    int cyc;
    @(negedge clk);
    walk_req_valid_i = 1; walk_vaddr_i = va; root_base_i = root;
    cyc = 0;
    while (!walk_req_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk({tag, "_req_ready"}, walk_req_ready_o, 1);
    @(negedge clk);
    walk_req_valid_i = 0; walk_vaddr_i = $urandom; root_base_i = $urandom;
    lat = 1;
    while (!walk_resp_valid_o && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  // Check the response, hold it for 'hold' cycles, then complete the handshake.
  task automatic finish_resp(input string tag, input logic [31:0] epa, input logic [2:0] eperm,
                             input logic efault, input int hold);
    chk({tag, "_valid"}, walk_resp_valid_o, 1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_paddr"}, walk_paddr_o, epa);
      @(negedge clk);
    end
    chk({tag, "_valid_held"}, walk_resp_valid_o, 1);
    chk({tag, "_paddr"}, walk_paddr_o, epa);
    chk({tag, "_perm"},  walk_perm_o,  eperm);
    chk({tag, "_fault"}, walk_fault_o, efault);
    chk({tag, "_no_req_in_resp"}, walk_req_ready_o, 0);
    walk_resp_ready_i = 1;
    @(negedge clk);
    walk_resp_ready_i = 0;
    chk({tag, "_resp_done"}, walk_resp_valid_o, 0);
    chk({tag, "_idle_ready"}, walk_req_ready_o, 1);
  endtask

  task automatic pulse_reset();
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic load_example();
    mem.delete();
    mem[32'h1004] = 32'h0000_2001;
    mem[32'h200C] = 32'h0000_5007;
  endtask

  initial begin : main
    int          lat, base, cyc, kind, nreq, hold;
    logic [31:0] root, va, a1, a0, ppn, junk, epa;
    logic [2:0]  perm, eperm;
    logic        efault;

    rst = 1; walk_req_valid_i = 0; walk_vaddr_i = 0; root_base_i = 0; walk_resp_ready_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  walk_req_ready_o, 0);
    chk("rst_resp_valid", walk_resp_valid_o, 0);
    chk("rst_mem_valid",  mem_req_valid_o, 0);
    chk("rst_mem_addr",   mem_addr_o, 0);
    chk("rst_mem_rready", mem_resp_ready_o, 0);
    chk("rst_paddr",      walk_paddr_o, 0);
    chk("rst_perm",       walk_perm_o, 0);
    chk("rst_fault",      walk_fault_o, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", walk_req_ready_o, 1);

    // Two-level walk with zero-wait memory.
    load_example();
    base = req_count;
    run_walk("walk2", 32'h0000_1000, 32'h0040_3ABC, lat);
    chk("walk2_latency", lat, 5);
    chk("walk2_mem_reqs", req_count - base, 2);
    finish_resp("walk2", 32'h0000_5ABC, 3'b011, 1'b0, 0);

    // Superpage leaf at level 1.
    mem.delete();
    mem[32'h1008] = 32'h00C0_0003;
    base = req_count;
    run_walk("super", 32'h0000_1000, 32'h0081_2345, lat);
    chk("super_latency", lat, 3);
    chk("super_mem_reqs", req_count - base, 1);
    finish_resp("super", 32'h00C1_2345, 3'b001, 1'b0, 0);

    // Invalid level-1 PTE.
    mem.delete();
    mem[32'h1004] = 32'h0000_2000;
    base = req_count;
    run_walk("l1inv", 32'h0000_1000, 32'h0040_3ABC, lat);
    chk("l1inv_mem_reqs", req_count - base, 1);
    finish_resp("l1inv", 32'h0, 3'b000, 1'b1, 0);

    // Memory never answers: fault TIMEOUT cycles after entering L1_WAIT.
    load_example();
    no_resp = 1;
    @(negedge clk);
    walk_req_valid_i = 1; walk_vaddr_i = 32'h0040_3ABC; root_base_i = 32'h0000_1000;
    @(negedge clk);
    walk_req_valid_i = 0;
    cyc = 0;
    while (!mem_resp_ready_o && cyc < 50) begin @(negedge clk); cyc++; end
    chk("tmo_in_wait", mem_resp_ready_o, 1);
    cyc = 0;
    while (!walk_resp_valid_o && cyc < TIMEOUT + 50) begin @(negedge clk); cyc++; end
    chk("tmo_latency", cyc, TIMEOUT);
    finish_resp("tmo", 32'h0, 3'b000, 1'b1, 0);
    no_resp = 0;
    pulse_reset();

    // Back-pressure on both memory request and walk response.
    load_example();
    cfg_stall = 4;
    base = req_count;
    run_walk("bp", 32'h0000_1000, 32'h0040_3ABC, lat);
    chk("bp_latency", lat, 13);
    chk("bp_mem_reqs", req_count - base, 2);
    finish_resp("bp", 32'h0000_5ABC, 3'b011, 1'b0, 3);
    cfg_stall = 0;

    // Reset in L0_WAIT, then a stale response while idle.
    load_example();
    cfg_rsp_dly = 20;
    base = req_count;
    @(negedge clk);
    walk_req_valid_i = 1; walk_vaddr_i = 32'h0040_3ABC; root_base_i = 32'h0000_1000;
    @(negedge clk);
    walk_req_valid_i = 0;
    cyc = 0;
    while (!(req_count == base + 2 && mem_resp_ready_o) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    chk("abort_in_l0_wait", mem_resp_ready_o, 1);
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; cfg_rsp_dly = 0; stale_cnt = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", walk_resp_valid_o, 0);
      chk("abort_no_mem_req", mem_req_valid_o, 0);
    end
    chk("abort_idle_ready", walk_req_ready_o, 1);
    base = req_count;
    run_walk("after_abort", 32'h0000_1000, 32'h0040_3ABC, lat);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_mem_reqs", req_count - base, 2);
    finish_resp("after_abort", 32'h0000_5ABC, 3'b011, 1'b0, 0);

    // Randomized walks against the model.
    for (int it = 0; it < 40; it++) begin
      mem.delete();
      root = $urandom; va = $urandom;
      a1   = (root & 32'hFFFF_F000) + (va >> 22) * 4;
      kind = $urandom_range(0, 5);
      perm = 3'($urandom_range(1, 7));
      if (perm[1] && !perm[0]) perm[0] = 1'b1;
      junk = $urandom & 32'h0000_0FF0;
      case (kind)
        0: begin
          ppn = $urandom & 32'hFFFF_F000;
          mem[a1] = ppn | junk | 32'h1;
          a0 = ppn + ((va >> 12) & 32'h3FF) * 4;
          mem[a0] = ($urandom & 32'hFFFF_F000) | junk | {28'h0, perm, 1'b1};
        end
        1: mem[a1] = ($urandom & 32'hFFC0_0000) | junk | {28'h0, perm, 1'b1};
        2: mem[a1] = $urandom & 32'hFFFF_FFFE;
        3: mem[a1] = ($urandom & 32'hFFC0_0000) | ($urandom_range(1, 1023) << 12) | junk | {28'h0, perm, 1'b1};
        4: begin
          ppn = $urandom & 32'hFFFF_F000;
          mem[a1] = ppn | junk | 32'h1;
          a0 = ppn + ((va >> 12) & 32'h3FF) * 4;
          if ($urandom_range(0, 1) == 0) mem[a0] = $urandom & 32'hFFFF_FFFE;
          else                           mem[a0] = ($urandom & 32'hFFFF_FFF0) | 32'h1;
        end
        default: begin
          perm = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b110;
          if ($urandom_range(0, 1) == 0) begin
            mem[a1] = ($urandom & 32'hFFC0_0000) | junk | {28'h0, perm, 1'b1};
          end else begin
            ppn = $urandom & 32'hFFFF_F000;
            mem[a1] = ppn | 32'h1;
            a0 = ppn + ((va >> 12) & 32'h3FF) * 4;
            mem[a0] = ($urandom & 32'hFFFF_F000) | junk | {28'h0, perm, 1'b1};
          end
        end
      endcase
      model(root, va, epa, eperm, efault, nreq);
      cfg_stall   = $urandom_range(0, 2);
      cfg_rsp_dly = $urandom_range(0, 3);
      hold        = $urandom_range(0, 2);
      base = req_count;
      run_walk($sformatf("rnd%0d", it), root, va, lat);
      chk($sformatf("rnd%0d_latency", it), lat, 1 + nreq * (2 + cfg_stall + cfg_rsp_dly));
      chk($sformatf("rnd%0d_mem_reqs", it), req_count - base, nreq);
      finish_resp($sformatf("rnd%0d", it), epa, eperm, efault, hold);
    end
    cfg_stall = 0; cfg_rsp_dly = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
